mips_register_file: RTL and testbench
=====================================

Name: mips_register_file

Overview:
- 32-entry × 32-bit general-purpose register file for the single-cycle MIPS datapath.
- Two combinational read ports serve the rs/rt operands.
- One synchronous write port serves the rd/rt destination.
- Register 0 is hardwired to zero, per MIPS $zero semantics.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, address width; depth = 2**ADDR_WIDTH (32 entries).

Ports:
- clk  input  1  system clock; writes occur on the rising edge.
- rst  input  1  asynchronous, active-high reset; clears all registers.
- r_a1  input  ADDR_WIDTH  read address, port 1 (rs).
- r_a2  input  ADDR_WIDTH  read address, port 2 (rt).
- w_a3  input  ADDR_WIDTH  write address (rd/rt).
- w_d  input  DATA_WIDTH  write data.
- w_e3  input  1  write enable, active high.
- r_d1  output  DATA_WIDTH  read data, port 1.
- r_d2  output  DATA_WIDTH  read data, port 2.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Storage: 2**ADDR_WIDTH registers of DATA_WIDTH bits.
- Reset:
  - On rst assertion, all registers clear to 0 immediately, without waiting for a clock edge.
  - While rst is high, writes are ignored and r_d1/r_d2 read 0.
  - A write coinciding with a clock edge during reset is discarded.
- Write:
  - At a rising edge of clk with rst=0 and w_e3=1, reg[w_a3] <= w_d.
  - With w_e3=0, no register changes.
  - A write to address 0 is accepted but discarded; reg[0] remains 0 permanently.
- Read:
  - Purely combinational, zero latency: r_d1 = reg[r_a1], r_d2 = reg[r_a2].
  - Outputs update whenever an address or the addressed register changes.
  - Address 0 always reads 0.
- Read-during-write, same address:
  - Before the edge, the read port returns the old contents.
  - After the edge, it returns the new value in the same cycle (combinational).
  - There is no internal bypass of w_d.
- Both read ports may address the same register, or the write address, simultaneously; they behave independently.
- Address wrap is not applicable: the full ADDR_WIDTH range is valid.
- Inputs containing X/Z are not specified; the bench drives known values.
- Initial state: all registers 0 after the first reset. Before any reset, contents are undefined; the bench must reset first.

Test Plan:
- Reset:
  - Stimulus: assert rst mid-cycle after registers 5 and 9 were written; check r_d1 with r_a1=5 and r_d2 with r_a2=9.
  - Response: both read 0 before the next clk edge.
- Basic write/read:
  - Stimulus: w_e3=1, w_a3=1, w_d=0x210000CA for one rising edge; then w_e3=0, w_d=0, r_a1=1, r_a2=0.
  - Response: r_d1=0x210000CA, r_d2=0x00000000.
- Enable gating:
  - Stimulus: w_e3=0, w_a3=7, w_d=0xDEADBEEF across several edges; r_a1=7.
  - Response: r_d1 stays 0.
- Zero register:
  - Stimulus: w_e3=1, w_a3=0, w_d=0xFFFFFFFF; clock; r_a1=0, r_a2=0.
  - Response: both read 0x00000000.
- Dual-port/all-registers sweep:
  - Stimulus: write reg[i]=i*0x01010101 for i=1..31; then read r_a1=i, r_a2=31-i.
  - Response: correct values on both ports for every i; address 0 reads 0.
- Read-during-write:
  - Stimulus: r_a1=3 holding 0x11111111; write w_a3=3, w_d=0x22222222.
  - Response: r_d1=0x11111111 before the rising edge and 0x22222222 immediately after it.

Source files
------------

// File: rtl/mips_register_file.sv
// 32 x 32-bit MIPS general-purpose register file.
// Two combinational read ports (rs/rt) and one synchronous write port (rd/rt).
// Register 0 is the hardwired $zero: it is never written and always reads 0.
module mips_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] r_a1,
  input  logic [ADDR_WIDTH-1:0] r_a2,
  input  logic [ADDR_WIDTH-1:0] w_a3,
  input  logic [DATA_WIDTH-1:0] w_d,
  input  logic                  w_e3,
  output logic [DATA_WIDTH-1:0] r_d1,
  output logic [DATA_WIDTH-1:0] r_d2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic                  wr_en;

  // Writes to address 0 are dropped here, so entry 0 only ever holds its reset value.
  assign wr_en = w_e3 && (w_a3 != '0);

  // Next-state array: current contents with at most one entry replaced.
  always_comb begin
    // NOTE: every always_comb output gets a full default first, so no path leaves it unassigned (no latch).
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[w_a3] = w_d;
    end
  end

  // Storage: cleared asynchronously on rst, otherwise loads the next-state array each edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: this memory is reset on purpose; architectural state must read 0 right after reset,
      // which forces flops rather than a RAM macro.
      for (int i = 0; i < DEPTH; i++) begin
        // NOTE: non-blocking assignment for all sequential state, so every flop samples pre-edge values.
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read port 1: zero-latency lookup of the stored value, no bypass of w_d; $zero forced to 0.
  always_comb begin
    r_d1 = regs_q[r_a1];
    if (r_a1 == '0) begin
      r_d1 = '0;
    end
  end

  // Read port 2: independent of port 1, same rules.
  always_comb begin
    r_d2 = regs_q[r_a2];
    if (r_a2 == '0) begin
      r_d2 = '0;
    end
  end

endmodule

// File: tb/tb_mips_register_file.sv
// Self-checking bench for mips_register_file: directed vector table, sweep,
// reset/read-during-write sequences, and random traffic against an array model.
module tb_mips_register_file;

  logic        clk;
  logic        rst;
  logic [4:0]  r_a1, r_a2, w_a3;
  logic [31:0] w_d;
  logic        w_e3;
  logic [31:0] r_d1, r_d2;

  int total = 0;
  int bad   = 0;

  mips_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk  (clk),
    .rst  (rst),
    .r_a1 (r_a1),
    .r_a2 (r_a2),
    .w_a3 (w_a3),
    .w_d  (w_d),
    .w_e3 (w_e3),
    .r_d1 (r_d1),
    .r_d2 (r_d2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [7];

  // Behavioural model: plain array of architectural register values.
  logic [31:0] model [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    w_e3 = 1'b1;
    w_a3 = a;
    w_d  = d;
    @(posedge clk);
    #1;
    w_e3 = 1'b0;
    w_d  = 32'h0;
  endtask

  initial begin
    rst  = 1'b1;
    r_a1 = '0;
    r_a2 = '0;
    w_a3 = '0;
    w_d  = '0;
    w_e3 = 1'b0;

    // Directed vectors: write on the edge, then read back after it.
    vecs[0] = '{1'b1, 5'd1,  32'h210000CA, 5'd1,  5'd0,  32'h210000CA, 32'h00000000};
    vecs[1] = '{1'b0, 5'd7,  32'hDEADBEEF, 5'd7,  5'd1,  32'h00000000, 32'h210000CA};
    vecs[2] = '{1'b0, 5'd7,  32'hDEADBEEF, 5'd7,  5'd7,  32'h00000000, 32'h00000000};
    vecs[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h00000000, 32'h00000000};
    vecs[4] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd1,  32'hA5A5A5A5, 32'h210000CA};
    vecs[5] = '{1'b1, 5'd1,  32'h12345678, 5'd1,  5'd31, 32'h12345678, 32'hA5A5A5A5};
    vecs[6] = '{1'b0, 5'd31, 32'h00000000, 5'd31, 5'd31, 32'hA5A5A5A5, 32'hA5A5A5A5};

    do_reset();

    // Reset state on a few addresses.
    r_a1 = 5'd5; r_a2 = 5'd9; #1;
    check("reset_rd1", r_d1, 32'h0);
    check("reset_rd2", r_d2, 32'h0);

    // Table-driven vectors.
    for (int v = 0; v < 7; v++) begin
      w_e3 = vecs[v].we;
      w_a3 = vecs[v].wa;
      w_d  = vecs[v].wd;
      r_a1 = vecs[v].ra1;
      r_a2 = vecs[v].ra2;
      @(posedge clk);
      #1;
      w_e3 = 1'b0;
      w_d  = 32'h0;
      #1;
      check($sformatf("vec%0d_rd1", v), r_d1, vecs[v].e1);
      check($sformatf("vec%0d_rd2", v), r_d2, vecs[v].e2);
    end

    // Enable gating over several edges.
    w_e3 = 1'b0; w_a3 = 5'd7; w_d = 32'hDEADBEEF; r_a1 = 5'd7;
    repeat (3) @(posedge clk);
    #1;
    check("gate_rd1", r_d1, 32'h0);

    // Full sweep: reg[i] = i * 0x01010101, read both ports crosswise.
    for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i) * 32'h01010101);
    for (int i = 0; i < 32; i++) begin
      r_a1 = 5'(i);
      r_a2 = 5'(31 - i);
      #1;
      check($sformatf("sweep_rd1_%0d", i), r_d1, 32'(i) * 32'h01010101);
      check($sformatf("sweep_rd2_%0d", i), r_d2, 32'(31 - i) * 32'h01010101);
    end

    // Read-during-write: old value before the edge, new value right after, no bypass.
    write_reg(5'd3, 32'h11111111);
    r_a1 = 5'd3; r_a2 = 5'd3;
    w_e3 = 1'b1; w_a3 = 5'd3; w_d = 32'h22222222;
    #1;
    check("rdw_before_rd1", r_d1, 32'h11111111);
    check("rdw_before_rd2", r_d2, 32'h11111111);
    @(posedge clk);
    #1;
    check("rdw_after_rd1", r_d1, 32'h22222222);
    check("rdw_after_rd2", r_d2, 32'h22222222);
    w_e3 = 1'b0;

    // Asynchronous reset mid-cycle after writing 5 and 9.
    write_reg(5'd5, 32'h55555555);
    write_reg(5'd9, 32'h99999999);
    r_a1 = 5'd5; r_a2 = 5'd9;
    #1;
    check("pre_rst_rd1", r_d1, 32'h55555555);
    check("pre_rst_rd2", r_d2, 32'h99999999);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_rd1", r_d1, 32'h0);
    check("async_rst_rd2", r_d2, 32'h0);
    // A write at an edge while reset is held must be discarded.
    w_e3 = 1'b1; w_a3 = 5'd5; w_d = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    check("rst_write_rd1", r_d1, 32'h0);
    w_e3 = 1'b0;
    rst = 1'b0;
    #1;
    check("post_rst_rd1", r_d1, 32'h0);
    check("post_rst_rd2", r_d2, 32'h0);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      w_e3 = 1'($urandom_range(0, 1));
      w_a3 = 5'($urandom_range(0, 31));
      w_d  = $urandom;
      r_a1 = 5'($urandom_range(0, 31));
      r_a2 = ($urandom_range(0, 3) == 0) ? w_a3 : 5'($urandom_range(0, 31));
      #1;
      check("rand_pre_rd1", r_d1, model[r_a1]);
      check("rand_pre_rd2", r_d2, model[r_a2]);
      @(posedge clk);
      if (w_e3 && w_a3 != 5'd0) model[w_a3] = w_d;
      #1;
      check("rand_post_rd1", r_d1, model[r_a1]);
      check("rand_post_rd2", r_d2, model[r_a2]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
